channel_readout_serializer: RTL and testbench

//  Consumer side of the channel-scan sequencer. On each load strobe (sl), samples the count
//  of the channel named by ch_addr and serializes {address, count} MSB-first on sdo.

---
 rtl/channel_readout_serializer_if.sv | 29 ++
 rtl/channel_readout_serializer.sv | 101 ++++++++++
 tb/tb_channel_readout_serializer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_readout_serializer_if.sv
// Bundle between the channel-scan sequencer (master) and the readout serializer (slave).
// state_dbg mirrors the serializer FSM state so checkers can observe it directly.
interface channel_readout_serializer_if #(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 4
);
    logic [NUM_CH*CNT_W-1:0] ch_counts;
    logic [ADDR_W-1:0]       ch_addr;
    logic                    sl;
    logic                    shift_en;
    logic                    clr_ovr;
    logic                    sdo;
    logic                    frame;
    logic                    done;
    logic                    bad_addr;
    logic                    overrun;
    logic [1:0]              state_dbg;

    modport master (
        output ch_counts, ch_addr, sl, shift_en, clr_ovr,
        input  sdo, frame, done, bad_addr, overrun, state_dbg
    );

    modport slave (
        input  ch_counts, ch_addr, sl, shift_en, clr_ovr,
        output sdo, frame, done, bad_addr, overrun, state_dbg
    );
endinterface

// File: rtl/channel_readout_serializer.sv
// Samples one channel count on sl and shifts {addr, count} MSB-first on sdo, paced by shift_en.
// Optional macro READOUT_PARITY_EN appends an even-parity bit after the count LSB.
module channel_readout_serializer #(
    parameter int NUM_CH = 10,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 4
) (
    input logic clk,
    input logic reset,
    channel_readout_serializer_if.slave bus
);
`ifdef READOUT_PARITY_EN
    localparam int FRAME_W = ADDR_W + CNT_W + 1;
`else
    localparam int FRAME_W = ADDR_W + CNT_W;
`endif
    localparam int CBW = $clog2(FRAME_W);

    // Handshake: sl is a single-cycle load request accepted only in IDLE (otherwise it
    // raises overrun); every cycle with shift_en high in SHIFT consumes the bit on sdo.
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [CBW-1:0]     bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0]   sel_cnt;
    logic [FRAME_W-1:0] load_word;
    logic               addr_bad;
    logic               load;

    assign addr_bad = ({1'b0, bus.ch_addr} >= (ADDR_W+1)'(NUM_CH));

    // Out-of-range addresses fall through the loop and load a zero count.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_addr == ADDR_W'(i)) sel_cnt = bus.ch_counts[i*CNT_W +: CNT_W];
        end
    end

`ifdef READOUT_PARITY_EN
    assign load_word = {bus.ch_addr, sel_cnt, ^{bus.ch_addr, sel_cnt}};
`else
    assign load_word = {bus.ch_addr, sel_cnt};
`endif

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sl) begin
                    load      = 1'b1;
                    shreg_n   = load_word;
                    bit_cnt_n = CBW'(FRAME_W - 1);
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (bit_cnt == '0) begin
                        state_n = DONE;
                    end else begin
                        shreg_n   = {shreg[FRAME_W-2:0], 1'b0};
                        bit_cnt_n = bit_cnt - CBW'(1);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            bus.sdo      <= 1'b0;
            bus.frame    <= 1'b0;
            bus.done     <= 1'b0;
            bus.bad_addr <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            bit_cnt      <= bit_cnt_n;
            bus.sdo      <= (state_n == SHIFT) ? shreg_n[FRAME_W-1] : 1'b0;
            bus.frame    <= (state_n == SHIFT);
            bus.done     <= (state_n == DONE);
            bus.bad_addr <= load & addr_bad;
            if (bus.sl && state != IDLE) bus.overrun <= 1'b1;
            else if (bus.clr_ovr)        bus.overrun <= 1'b0;
        end
    end

    assign bus.state_dbg = state;
endmodule

// File: tb/tb_channel_readout_serializer.sv
// Self-checking bench for channel_readout_serializer; expected serial bits come from a
// frame model pushed into exp_q at load time and popped as each bit is consumed.
module tb_channel_readout_serializer;
  localparam int NUM_CH = 10;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 4;
`ifdef READOUT_PARITY_EN
  localparam int FW = ADDR_W + CNT_W + 1;
`else
  localparam int FW = ADDR_W + CNT_W;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  channel_readout_serializer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  channel_readout_serializer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  logic [CNT_W-1:0] counts [NUM_CH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(input int ch, input logic [CNT_W-1:0] v);
    counts[ch] = v;
    bus.ch_counts[ch*CNT_W +: CNT_W] = v;
  endtask

  // Reference model of one frame: address, sampled count (zero if out of range), parity.
  task automatic push_frame(input logic [ADDR_W-1:0] a);
    logic [CNT_W-1:0] c;
    logic [FW-1:0] f;
    c = '0;
    if (int'(a) < NUM_CH) c = counts[int'(a)];
`ifdef READOUT_PARITY_EN
    f = {a, c, ^{a, c}};
`else
    f = {a, c};
`endif
    for (int i = FW - 1; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic with_shift);
    bus.ch_addr  = a;
    bus.sl       = 1'b1;
    bus.shift_en = with_shift;
    push_frame(a);
    tick();
    bus.sl       = 1'b0;
    bus.shift_en = 1'b0;
    checks++;
    if (bus.frame !== 1'b1 || bus.sdo !== exp_q[0]) begin
      errors++;
      $display("FAIL load_first_bit addr=%0d: frame=%b sdo=%b, required frame=1 sdo=%b", a, bus.frame, bus.sdo, exp_q[0]);
    end
  endtask

  // Consume n bits, shift_en every gap cycles; checks hold and consumed bit values.
  task automatic drain(input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: bit %0d requested with empty queue", b);
        break;
      end
      for (int h = 1; h < gap; h++) begin
        checks++;
        if (bus.sdo !== exp_q[0] || bus.frame !== 1'b1) begin
          errors++;
          $display("FAIL bit_hold: sdo=%b frame=%b, required sdo=%b frame=1", bus.sdo, bus.frame, exp_q[0]);
        end
        tick();
      end
      bus.shift_en = 1'b1;
      checks++;
      if (bus.sdo !== exp_q[0] || bus.frame !== 1'b1) begin
        errors++;
        $display("FAIL serial_bit: sdo=%b frame=%b, required sdo=%b frame=1", bus.sdo, bus.frame, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      bus.shift_en = 1'b0;
    end
    if (exp_q.size() == 0) begin
      checks++;
      if (bus.frame !== 1'b0 || bus.done !== 1'b1 || bus.sdo !== 1'b0) begin
        errors++;
        $display("FAIL frame_end: frame=%b done=%b sdo=%b, required 0/1/0", bus.frame, bus.done, bus.sdo);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.sdo, bus.frame, bus.done, bus.bad_addr, bus.overrun} !== 5'b0 || bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: sdo/frame/done/bad/ovr=%b state=%0d, required 00000 state=0",
               {bus.sdo, bus.frame, bus.done, bus.bad_addr, bus.overrun}, bus.state_dbg);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.frame !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: frame=%b done=%b, required 0/0", bus.frame, bus.done);
    end
  endtask

  task automatic test_basic();
    set_count(3, 8'hA5);
    load(4'd3, 1'b0);
    checks++;
    if (bus.bad_addr !== 1'b0) begin
      errors++;
      $display("FAIL basic_bad_addr: bad_addr=%b, required 0", bus.bad_addr);
    end
    drain(FW, 1);
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b, required 0", bus.done);
    end
  endtask

  task automatic test_throttled();
    set_count(3, 8'hA5);
    load(4'd3, 1'b0);
    set_count(3, 8'h5A);
    for (int i = 0; i < NUM_CH; i++) if (i != 3) set_count(i, CNT_W'($urandom_range(0, 255)));
    drain(FW, 4);
    tick();
  endtask

  task automatic test_bad_addr();
    load(4'hC, 1'b0);
    checks++;
    if (bus.bad_addr !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_pulse: bad_addr=%b, required 1", bus.bad_addr);
    end
    tick();
    checks++;
    if (bus.bad_addr !== 1'b0 || bus.sdo !== exp_q[0]) begin
      errors++;
      $display("FAIL bad_addr_clear: bad_addr=%b sdo=%b, required 0 sdo=%b", bus.bad_addr, bus.sdo, exp_q[0]);
    end
    drain(FW, 1);
    tick();
  endtask

  task automatic test_overrun();
    set_count(2, CNT_W'($urandom_range(0, 255)));
    load(4'd2, 1'b0);
    drain(5, 1);
    bus.ch_addr = 4'd7;
    bus.sl = 1'b1;
    tick();
    bus.sl = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.frame !== 1'b1 || bus.sdo !== exp_q[0]) begin
      errors++;
      $display("FAIL overrun_set: ovr=%b frame=%b sdo=%b, required 1/1/%b", bus.overrun, bus.frame, bus.sdo, exp_q[0]);
    end
    drain(FW - 5, 2);
    tick();
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: ovr=%b, required 1", bus.overrun);
    end
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: ovr=%b, required 0", bus.overrun);
    end
    load(4'd2, 1'b0);
    drain(2, 1);
    bus.sl = 1'b1;
    bus.clr_ovr = 1'b1;
    tick();
    bus.sl = 1'b0;
    bus.clr_ovr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: ovr=%b, required 1", bus.overrun);
    end
    drain(FW - 2, 1);
    tick();
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    set_count(6, CNT_W'($urandom_range(0, 255)));
    load(4'd6, 1'b1);
    drain(FW, 1);
    tick();
  endtask

  task automatic test_back_to_back();
    set_count(8, CNT_W'($urandom_range(0, 255)));
    set_count(9, CNT_W'($urandom_range(0, 255)));
    load(4'd8, 1'b0);
    drain(FW, 1);
    bus.ch_addr = 4'd9;
    bus.sl = 1'b1;
    tick();
    checks++;
    if (bus.overrun !== 1'b1 || bus.frame !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reject: ovr=%b frame=%b done=%b, required 1/0/0", bus.overrun, bus.frame, bus.done);
    end
    load(4'd9, 1'b0);
    drain(FW, 1);
    tick();
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
  endtask

  task automatic test_async_reset();
    set_count(5, CNT_W'($urandom_range(0, 255)));
    load(4'd5, 1'b0);
    drain(6, 1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.frame !== 1'b0 || bus.sdo !== 1'b0 || bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: frame=%b sdo=%b state=%0d, required 0/0/0", bus.frame, bus.sdo, bus.state_dbg);
    end
    exp_q.delete();
    #2;
    reset = 1'b0;
    tick();
    set_count(0, 8'hFF);
    load(4'd0, 1'b0);
    drain(FW, 1);
    tick();
  endtask

`ifdef READOUT_PARITY_EN
  task automatic test_parity();
    set_count(1, 8'h01);
    load(4'd1, 1'b0);
    drain(FW, 1);
    tick();
    set_count(1, 8'h03);
    load(4'd1, 1'b0);
    drain(FW, 1);
    tick();
  endtask
`endif

  initial begin
    reset        = 1'b1;
    bus.ch_counts = '0;
    bus.ch_addr  = '0;
    bus.sl       = 1'b0;
    bus.shift_en = 1'b0;
    bus.clr_ovr  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) counts[i] = '0;

    test_reset();
    test_basic();
    test_throttled();
    test_bad_addr();
    test_overrun();
    test_back_to_back();
    test_async_reset();
`ifdef READOUT_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d bits left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
